// File: rtl/register_file_2r1w.sv
// ----------------------------------------------------------------------------
// register_file_2r1w
//
// Purpose:
//    General-purpose register file with 32 entries of 32 bits. It has two
//    registered read ports that feed the ALU op1/op2 operands, and one write
//    port that takes the ALU result for writeback. R0 always reads as zero.
//    RD_VALID is high for the one cycle after each accepted READ strobe.
//
// Ports:
//    CLK       in   1           system clock, rising edge
//    RST       in   1           synchronous reset, active-low
//    ADDR_R1   in   ADDR_WIDTH  read port 1 address (op1)
//    ADDR_R2   in   ADDR_WIDTH  read port 2 address (op2)
//    ADDR_W    in   ADDR_WIDTH  write address
//    DATA_W    in   DATA_WIDTH  write data
//    READ      in   1           read strobe
//    WRITE     in   1           write strobe
//    DATA_R1   out  DATA_WIDTH  registered read data, port 1
//    DATA_R2   out  DATA_WIDTH  registered read data, port 2
//    RD_VALID  out  1           read data valid, one cycle after READ
//
// Build option:
//    REG_FILE_WRITE_BYPASS_EN
//       Defined: a READ and a WRITE in the same cycle to the same nonzero
//       address return the new write data (write-first), independently on
//       each port.
//       Undefined: the read returns the previously stored value
//       (read-first). In both builds the write itself completes.
// ----------------------------------------------------------------------------
module register_file_2r1w #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_COUNT  = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] ADDR_R1,
   input  logic [ADDR_WIDTH-1:0] ADDR_R2,
   input  logic [ADDR_WIDTH-1:0] ADDR_W,
   input  logic [DATA_WIDTH-1:0] DATA_W,
   input  logic                  READ,
   input  logic                  WRITE,
   output logic [DATA_WIDTH-1:0] DATA_R1,
   output logic [DATA_WIDTH-1:0] DATA_R2,
   output logic                  RD_VALID
);

   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d;
   logic [DATA_WIDTH-1:0] data_r2_q, data_r2_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd1_val;
   logic [DATA_WIDTH-1:0] rd2_val;

   // A write to R0 is dropped here. R0 is never loaded, so it stays at its
   // reset value of zero.
   assign wr_en = WRITE && (ADDR_W != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[ADDR_W] = DATA_W;
      end
   end

   // Read-port selection. Address 0 is forced to zero explicitly, so the
   // zero result does not rely on regs_q[0] alone.
   always_comb begin
      rd1_val = (ADDR_R1 == '0) ? '0 : regs_q[ADDR_R1];
      rd2_val = (ADDR_R2 == '0) ? '0 : regs_q[ADDR_R2];
`ifdef REG_FILE_WRITE_BYPASS_EN
      // Write-first forwarding. wr_en already excludes ADDR_W == 0.
      if (wr_en && (ADDR_W == ADDR_R1)) begin
         rd1_val = DATA_W;
      end
      if (wr_en && (ADDR_W == ADDR_R2)) begin
         rd2_val = DATA_W;
      end
`endif
   end

   // Output registers hold their value while READ is low.
   always_comb begin
      data_r1_d  = data_r1_q;
      data_r2_d  = data_r2_q;
      rd_valid_d = READ;
      if (READ) begin
         data_r1_d = rd1_val;
         data_r2_d = rd2_val;
      end
   end

   // Reset clears the whole array as well as the outputs, so any pending
   // read is discarded and every later read returns zero.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
         data_r1_q  <= '0;
         data_r2_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         data_r1_q  <= data_r1_d;
         data_r2_q  <= data_r2_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign DATA_R1  = data_r1_q;
   assign DATA_R2  = data_r2_q;
   assign RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// ----------------------------------------------------------------------------
// tb_register_file_2r1w
//
// Purpose:
//    Directed bench for register_file_2r1w. Each step drives the inputs,
//    crosses one rising CLK edge, and then compares the outputs with values
//    worked out by hand.
//
// Build option:
//    REG_FILE_WRITE_BYPASS_EN selects the expected value for the same-cycle
//    read/write hazard.
// ----------------------------------------------------------------------------
module tb_register_file_2r1w;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          CLK;
   logic          RST;
   logic [AW-1:0] ADDR_R1;
   logic [AW-1:0] ADDR_R2;
   logic [AW-1:0] ADDR_W;
   logic [DW-1:0] DATA_W;
   logic          READ;
   logic          WRITE;
   logic [DW-1:0] DATA_R1;
   logic [DW-1:0] DATA_R2;
   logic          RD_VALID;

   int checks = 0;
   int errors = 0;

   register_file_2r1w #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .REG_COUNT  (32)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ADDR_R1  (ADDR_R1),
      .ADDR_R2  (ADDR_R2),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .READ     (READ),
      .WRITE    (WRITE),
      .DATA_R1  (DATA_R1),
      .DATA_R2  (DATA_R2),
      .RD_VALID (RD_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cross one rising edge. Outputs are sampled 1 time unit later, away
   // from the active edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [DW-1:0] r1,
                            input logic [DW-1:0] r2, input logic v);
      check({tag, ".R1"}, DATA_R1, r1);
      check({tag, ".R2"}, DATA_R2, r2);
      check({tag, ".VLD"}, {31'd0, RD_VALID}, {31'd0, v});
   endtask

   // Drive every input for the next edge.
   task automatic drive(input logic rst, input logic rd, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic wr,
                        input logic [AW-1:0] aw, input logic [DW-1:0] dw);
      RST = rst; READ = rd; ADDR_R1 = a1; ADDR_R2 = a2;
      WRITE = wr; ADDR_W = aw; DATA_W = dw;
   endtask

   logic [DW-1:0] hazard_exp;

   initial begin
`ifdef REG_FILE_WRITE_BYPASS_EN
      hazard_exp = 32'd99;
`else
      hazard_exp = 32'd20;
`endif
      // Reset state
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
      step();
      step();
      check_out("reset", 32'd0, 32'd0, 1'b0);

      // Reset clears a written register
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
      step();
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
      step();
      drive(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
      step();
      check_out("rst_clear", 32'd0, 32'd0, 1'b1);
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
      step();
      check("rst_clear_vld_drop", {31'd0, RD_VALID}, 32'd0);

      // Basic write then read
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'd15);
      step();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'd5);
      step();
      drive(1'b1, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0);
      step();
      check_out("basic", 32'd15, 32'd5, 1'b1);

      // Hold: READ low for 3 cycles while R3 is rewritten
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 5'd3, 32'd1);
         step();
         check_out($sformatf("hold%0d", i), 32'd15, 32'd5, 1'b0);
      end

      // Back-to-back reads, including the new R3 and equal addresses
      drive(1'b1, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0);
      step();
      check_out("b2b0", 32'd1, 32'd5, 1'b1);
      drive(1'b1, 1'b1, 5'd4, 5'd3, 1'b0, 5'd0, 32'd0);
      step();
      check_out("b2b1", 32'd5, 32'd1, 1'b1);
      drive(1'b1, 1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 32'd0);
      step();
      check_out("same_addr", 32'd5, 32'd5, 1'b1);

      // R0 hardwired to zero
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFF0);
      step();
      drive(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
      step();
      check_out("r0", 32'd0, 32'd0, 1'b1);
      // A write to R0 in the same cycle as a read of R0 is never forwarded
      drive(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'd123);
      step();
      check_out("r0_fwd", 32'd0, 32'd0, 1'b1);

      // Same-cycle hazard on R7. Port 2 reads an unrelated register (R3).
      drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'd20);
      step();
      drive(1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 32'd99);
      step();
      check_out("hazard", hazard_exp, 32'd1, 1'b1);
      drive(1'b1, 1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'd0);
      step();
      check_out("hazard_after", 32'd1, 32'd99, 1'b1);

      // Reset takes priority over READ and WRITE on the same edge
      drive(1'b0, 1'b1, 5'd7, 5'd9, 1'b1, 5'd9, 32'd42);
      step();
      check_out("rst_prio", 32'd0, 32'd0, 1'b0);
      drive(1'b1, 1'b1, 5'd9, 5'd7, 1'b0, 5'd0, 32'd0);
      step();
      check_out("rst_prio_after", 32'd0, 32'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
